snake_engine: RTL and testbench
===============================

# snake_engine

Grid-based snake game core, successor to the single-box player mover. It holds a multi-segment snake body, applies one move per `step` pulse, and handles food, growth, score, and wall/self collision. It also produces the registered RGB colour for the current VGA pixel. It sits between the button/action decoder (`accion`, `step` tick) and the VGA timing block (`PixelX`/`PixelY` in, R/G/B out), all in one clock domain.

## Interface
Parameters:
- `CELL_PX`, 10, pixel side of one grid cell.
- `GRID_W`, 80, cells horizontally; must be ≤ 128.
- `GRID_H`, 60, cells vertically; must be ≤ 128.
- `MAX_LEN`, 16, segment storage depth (maximum snake length).
- `INIT_LEN`, 3, length after reset; 1 ≤ INIT_LEN ≤ MAX_LEN.
- `INIT_X`, 4, head cell x after reset; must be ≥ INIT_LEN-1.
- `INIT_Y`, 4, head cell y after reset.
- `FOOD0_X`, 20, first food cell x.
- `FOOD0_Y`, 20, first food cell y.

Ports:
- `uclk`  in  1  system/pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `step`  in  1  one-cycle move pulse, synchronous to `uclk`.
- `accion`  in  3  requested direction: 1 up, 2 down, 3 left, 4 right; other values mean no request.
- `PixelX`  in  11  current pixel column.
- `PixelY`  in  11  current pixel row.
- `R`  out  3  pixel red.
- `G`  out  3  pixel green.
- `B`  out  2  pixel blue.
- `length`  out  $clog2(MAX_LEN+1)  current segment count.
- `score`  out  8  food eaten, saturating at 255.
- `game_over`  out  1  high in the OVER state.

## Operation
- Cell coordinates are 7-bit unsigned x and y. Segment 0 is the head; segments `length`..MAX_LEN-1 are don't-care.
- **Direction register**
  - Latches a valid `accion` on every cycle.
  - A request that is the exact reverse of the current direction is ignored.
  - Applies at the next `step`.
  - Reset value is right.
- **FSM states**
  - PLAY: on `step`, compute the next head position = head ± 1 in the direction register.
    - Next head outside 0..GRID_W-1 / 0..GRID_H-1 → OVER. Unsigned underflow of 0-1 also counts as outside.
    - Next head equal to any segment 1..length-1 → OVER. The tail is excluded when not eating; the tail is included when eating.
    - Otherwise, shift body down one place and write the new head.
    - If the next head equals the food cell and `food_valid` = 1:
      - `length` increments, saturating at MAX_LEN.
      - `score` increments, saturating at 255.
      - `food_valid` clears and a relocation starts.
      - At MAX_LEN the snake still eats, but length holds and the last segment drops.
  - OVER: the body is frozen and `step` is ignored. Only reset leaves OVER.
- **Food relocation**
  - A free-running 16-bit LFSR is stepped every cycle: x^16+x^14+x^13+x^11, seed 16'hACE1.
  - While `food_valid` = 0, each cycle forms a candidate: x = lfsr[6:0], y = lfsr[13:7].
  - The candidate is accepted when x < GRID_W, y < GRID_H, and it matches no active segment. Acceptance sets `food_valid`.
  - Food cannot be eaten while invalid.
- **Rendering**
  - cell = PixelX / CELL_PX, PixelY / CELL_PX (constant division).
  - Colours, in priority order:
    - Outside grid → 000/000/00.
    - Head → 000/000/11.
    - Body → 000/101/00.
    - Food, when valid → 111/000/00.
    - Background → 111/111/11 in PLAY, 100/000/00 in OVER.
- **Reset values**
  - Head at (INIT_X, INIT_Y), segment i at (INIT_X-i, INIT_Y).
  - `length` = INIT_LEN, `score` = 0, `game_over` = 0.
  - Food at (FOOD0_X, FOOD0_Y) with `food_valid` = 1.
  - R/G/B = 0.

## Timing
- Move latency: body, length, score and `game_over` update on the `uclk` edge where `step` = 1 and are visible the next cycle.
- `accion` arriving in the same cycle as `step` is not used for that move; it applies to the next move.
- Render latency: R/G/B are registered, one cycle after PixelX/PixelY.
- Relocation takes ≥1 cycle after eating, unbounded but typically under 8 cycles. A `step` during relocation moves normally without eating.
- Reset asserted mid-move or mid-relocation clears all state immediately; the first `step` is honoured on the cycle after deassertion.
- Collision checks and the body hit test are parallel (MAX_LEN comparators), with no multi-cycle scan.

## Structure
- Package `snake_pkg`:
  - direction encodings (DIR_UP=1, DIR_DOWN=2, DIR_LEFT=3, DIR_RIGHT=4)
  - FSM state encodings (PLAY, OVER)
  - colour constants
  - coordinate width constant (7).
- Sub-module `snake_food_gen`: LFSR, candidate bounds check, body-overlap check, food register and `food_valid`. Body occupancy arrives as a flattened vector.
- The top holds the direction register, FSM, body shift array, counters and the render pipeline stage.

## Test plan
- Reset, then 3 `step`s with no `accion` → head (7,4), length 3, pixel (75,45) renders blue one cycle after presentation.
- FOOD0 = (6,4), 2 `step`s → length 4, score 1, `food_valid` low for ≥1 cycle, then the new food lies inside the grid and off the body.
- Head (4,4) moving right, `accion`=3 → ignored; `accion`=1 then `step` → head (4,3).
- INIT_Y = 0, `accion`=1, `step` → `game_over` = 1, background 100/000/00, and further `step`s leave the head at (4,0).
- Length 5 in a U-turn (up, left, down) into its own body → OVER. Moving into the vacating tail cell → no OVER.
- Reset pulsed low during relocation → all reset values the next cycle, food at FOOD0, `food_valid` = 1.

Source files
------------

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake game core: grid coordinate width,
// direction and FSM encodings, the RGB pixel format with its palette, the
// food LFSR seed and small direction helpers.
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int COORD_W = 7;            // bits per cell coordinate
    localparam int SEG_W   = 2 * COORD_W;  // one packed {y, x} segment
    localparam int PIX_W   = 11;           // VGA pixel coordinate width

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK   = '{r: 3'b000, g: 3'b000, b: 2'b00};
    localparam rgb_t RGB_HEAD    = '{r: 3'b000, g: 3'b000, b: 2'b11};
    localparam rgb_t RGB_BODY    = '{r: 3'b000, g: 3'b101, b: 2'b00};
    localparam rgb_t RGB_FOOD    = '{r: 3'b111, g: 3'b000, b: 2'b00};
    localparam rgb_t RGB_BG_PLAY = '{r: 3'b111, g: 3'b111, b: 2'b11};
    localparam rgb_t RGB_BG_OVER = '{r: 3'b100, g: 3'b000, b: 2'b00};

    // Raw 3-bit request is one of the four legal directions.
    function automatic logic dir_valid(input logic [2:0] req);
        return (req >= 3'd1) && (req <= 3'd4);
    endfunction

    // Request points exactly opposite to the current heading.
    function automatic logic dir_reverse(input dir_e cur, input logic [2:0] req);
        logic rev;
        rev = 1'b0;
        case (cur)
            DIR_UP:    rev = (req == DIR_DOWN);
            DIR_DOWN:  rev = (req == DIR_UP);
            DIR_LEFT:  rev = (req == DIR_RIGHT);
            DIR_RIGHT: rev = (req == DIR_LEFT);
            default:   rev = 1'b0;
        endcase
        return rev;
    endfunction

endpackage

// File: rtl/snake_food_gen.sv
// -----------------------------------------------------------------------------
// snake_food_gen
// Holds the food cell and its valid flag. A free-running 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11) proposes one candidate cell per cycle while the food
// is invalid; the first candidate inside the grid and off every active snake
// segment becomes the new food.
//
// Ports:
//   uclk          clock
//   reset         asynchronous active-low reset
//   i_eat         food consumed this cycle; clears valid, starts relocation
//   i_body_xy     all segments flattened, segment i = {y, x} at [i*SEG_W +: SEG_W]
//   i_seg_active  bit i set when segment i is part of the snake
//   o_food_x/y    food cell
//   o_food_valid  food is present and may be eaten
// -----------------------------------------------------------------------------
module snake_food_gen
    import snake_pkg::*;
#(
    parameter int GRID_W  = 80,
    parameter int GRID_H  = 60,
    parameter int MAX_LEN = 16,
    parameter int FOOD0_X = 20,
    parameter int FOOD0_Y = 20
) (
    input  logic                     uclk,
    input  logic                     reset,
    input  logic                     i_eat,
    input  logic [MAX_LEN*SEG_W-1:0] i_body_xy,
    input  logic [MAX_LEN-1:0]       i_seg_active,
    output coord_t                   o_food_x,
    output coord_t                   o_food_y,
    output logic                     o_food_valid
);

    logic [15:0] r_lfsr;
    coord_t      r_food_x;
    coord_t      r_food_y;
    logic        r_food_valid;

    coord_t      w_cand_x;
    coord_t      w_cand_y;
    logic        w_in_grid;
    logic        w_overlap;
    logic        w_accept;
    logic        w_fb;

    always_comb begin
        // NOTE: every signal gets a value before any conditional logic so no
        // path leaves it unassigned and no latch is inferred.
        w_cand_x  = r_lfsr[6:0];
        w_cand_y  = r_lfsr[13:7];
        w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        // One spare bit keeps the bound correct when the grid spans all 128 cells.
        w_in_grid = ({1'b0, w_cand_x} < 8'(GRID_W)) && ({1'b0, w_cand_y} < 8'(GRID_H));
        w_overlap = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i_seg_active[i] && (i_body_xy[i*SEG_W +: SEG_W] == {w_cand_y, w_cand_x})) begin
                w_overlap = 1'b1;
            end
        end
        w_accept  = !r_food_valid && w_in_grid && !w_overlap;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            r_lfsr       <= LFSR_SEED;
            r_food_x     <= coord_t'(FOOD0_X);
            r_food_y     <= coord_t'(FOOD0_Y);
            r_food_valid <= 1'b1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            if (i_eat) begin
                r_food_valid <= 1'b0;
            end else if (w_accept) begin
                r_food_x     <= w_cand_x;
                r_food_y     <= w_cand_y;
                r_food_valid <= 1'b1;
            end
        end
    end

    assign o_food_x     = r_food_x;
    assign o_food_y     = r_food_y;
    assign o_food_valid = r_food_valid;

endmodule

// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
// Grid snake game core. Keeps the segment array (segment 0 = head), applies one
// move per step pulse in the latched direction, detects wall and self
// collisions, grows and scores on food, and renders one registered RGB pixel
// per cycle for the VGA timing block.
//
// Ports:
//   uclk        clock (only clock domain)
//   reset       asynchronous active-low reset
//   step        one-cycle move pulse
//   accion      direction request: 1 up, 2 down, 3 left, 4 right, else none
//   PixelX/Y    current VGA pixel
//   R/G/B       registered pixel colour, one cycle after PixelX/Y
//   length      current segment count
//   score       food eaten, saturating at 255
//   game_over   high once a collision has ended the game
// -----------------------------------------------------------------------------
module snake_engine
    import snake_pkg::*;
#(
    parameter int CELL_PX  = 10,
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 4,
    parameter int INIT_Y   = 4,
    parameter int FOOD0_X  = 20,
    parameter int FOOD0_Y  = 20
) (
    input  logic                           uclk,
    input  logic                           reset,
    input  logic                           step,
    input  logic [2:0]                     accion,
    input  logic [PIX_W-1:0]               PixelX,
    input  logic [PIX_W-1:0]               PixelY,
    output logic [2:0]                     R,
    output logic [2:0]                     G,
    output logic [1:0]                     B,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [7:0]                     score,
    output logic                           game_over
);

    localparam int LEN_W = $clog2(MAX_LEN+1);

    // ---------------------------------------------------------------- state
    state_e             r_state;
    dir_e               r_dir;
    coord_t             r_body_x [MAX_LEN];
    coord_t             r_body_y [MAX_LEN];
    logic [LEN_W-1:0]   r_length;
    logic [7:0]         r_score;
    rgb_t               r_rgb;

    // ---------------------------------------------------------------- wires
    state_e             w_state_next;
    logic               w_move;
    logic               w_game_over;
    coord_t             w_next_x;
    coord_t             w_next_y;
    logic               w_wall_hit;
    logic               w_self_hit;
    logic               w_collide;
    logic               w_eat;
    logic [LEN_W-1:0]   w_check_len;
    logic [MAX_LEN-1:0] w_seg_active;
    logic [MAX_LEN*SEG_W-1:0] w_body_xy;
    coord_t             w_food_x;
    coord_t             w_food_y;
    logic               w_food_valid;
    logic [PIX_W-1:0]   w_cell_x;
    logic [PIX_W-1:0]   w_cell_y;
    logic               w_in_grid;
    logic               w_body_px;
    rgb_t               w_pix_rgb;

    function automatic logic on_cell(input logic [PIX_W-1:0] cx, input logic [PIX_W-1:0] cy,
                                     input coord_t x, input coord_t y);
        return (cx == PIX_W'(x)) && (cy == PIX_W'(y));
    endfunction

    // ------------------------------------------------------ direction latch
    // The move on a step edge uses the old direction, so a request arriving
    // with step only takes effect on the following move.
    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            r_dir <= DIR_RIGHT;
        end else if (dir_valid(accion) && !dir_reverse(r_dir, accion)) begin
            r_dir <= dir_e'(accion);
        end
    end

    // ------------------------------------------------------- next head cell
    // Walls are tested before the +/-1 so 0-1 never wraps into a legal cell.
    always_comb begin
        w_next_x   = r_body_x[0];
        w_next_y   = r_body_y[0];
        w_wall_hit = 1'b0;
        case (r_dir)
            DIR_UP: begin
                if (r_body_y[0] == '0) w_wall_hit = 1'b1;
                else                   w_next_y   = r_body_y[0] - 1'b1;
            end
            DIR_DOWN: begin
                if (r_body_y[0] == coord_t'(GRID_H-1)) w_wall_hit = 1'b1;
                else                                   w_next_y   = r_body_y[0] + 1'b1;
            end
            DIR_LEFT: begin
                if (r_body_x[0] == '0) w_wall_hit = 1'b1;
                else                   w_next_x   = r_body_x[0] - 1'b1;
            end
            DIR_RIGHT: begin
                if (r_body_x[0] == coord_t'(GRID_W-1)) w_wall_hit = 1'b1;
                else                                   w_next_x   = r_body_x[0] + 1'b1;
            end
            default: w_wall_hit = 1'b0;
        endcase
    end

    // ------------------------------------------------- eat / self collision
    // The tail cell is vacated on a plain move, so it is only an obstacle when
    // the snake eats and the tail stays put.
    always_comb begin
        w_eat       = w_food_valid && (w_next_x == w_food_x) && (w_next_y == w_food_y);
        w_check_len = w_eat ? r_length : (r_length - LEN_W'(1));
        w_self_hit  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < w_check_len) &&
                (r_body_x[i] == w_next_x) && (r_body_y[i] == w_next_y)) begin
                w_self_hit = 1'b1;
            end
        end
        w_collide = w_wall_hit || w_self_hit;
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) r_state <= ST_PLAY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_move       = 1'b0;
        w_game_over  = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (step) begin
                    if (w_collide) w_state_next = ST_OVER;
                    else           w_move       = 1'b1;
                end
            end
            ST_OVER: begin
                w_game_over = 1'b1;
            end
            default: w_state_next = ST_PLAY;
        endcase
    end

    // ----------------------------------------------------------- body array
    // NOTE: the segment array is reset because the starting snake is visible
    // game state; entries beyond INIT_LEN are cleared only for determinism.
    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body_x[i] <= (i < INIT_LEN) ? coord_t'(INIT_X - i) : '0;
                r_body_y[i] <= (i < INIT_LEN) ? coord_t'(INIT_Y)     : '0;
            end
        end else if (w_move) begin
            r_body_x[0] <= w_next_x;
            r_body_y[0] <= w_next_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                r_body_x[i] <= r_body_x[i-1];
                r_body_y[i] <= r_body_y[i-1];
            end
        end
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) begin
            r_length <= LEN_W'(INIT_LEN);
            r_score  <= '0;
        end else if (w_move && w_eat) begin
            if (r_length != LEN_W'(MAX_LEN)) r_length <= r_length + LEN_W'(1);
            if (r_score != 8'hFF)            r_score  <= r_score + 8'd1;
        end
    end

    // -------------------------------------------------------- food generator
    always_comb begin
        w_body_xy = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_body_xy[i*SEG_W +: SEG_W] = {r_body_y[i], r_body_x[i]};
            w_seg_active[i]             = (LEN_W'(i) < r_length);
        end
    end

    snake_food_gen #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .MAX_LEN (MAX_LEN),
        .FOOD0_X (FOOD0_X),
        .FOOD0_Y (FOOD0_Y)
    ) u_food (
        .uclk         (uclk),
        .reset        (reset),
        .i_eat        (w_move && w_eat),
        .i_body_xy    (w_body_xy),
        .i_seg_active (w_seg_active),
        .o_food_x     (w_food_x),
        .o_food_y     (w_food_y),
        .o_food_valid (w_food_valid)
    );

    // --------------------------------------------------------------- render
    always_comb begin
        w_cell_x  = PixelX / PIX_W'(CELL_PX);
        w_cell_y  = PixelY / PIX_W'(CELL_PX);
        w_in_grid = (w_cell_x < PIX_W'(GRID_W)) && (w_cell_y < PIX_W'(GRID_H));
        w_body_px = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (w_seg_active[i] && on_cell(w_cell_x, w_cell_y, r_body_x[i], r_body_y[i])) begin
                w_body_px = 1'b1;
            end
        end
        w_pix_rgb = (r_state == ST_OVER) ? RGB_BG_OVER : RGB_BG_PLAY;
        if (!w_in_grid) begin
            w_pix_rgb = RGB_BLACK;
        end else if (on_cell(w_cell_x, w_cell_y, r_body_x[0], r_body_y[0])) begin
            w_pix_rgb = RGB_HEAD;
        end else if (w_body_px) begin
            w_pix_rgb = RGB_BODY;
        end else if (w_food_valid && on_cell(w_cell_x, w_cell_y, w_food_x, w_food_y)) begin
            w_pix_rgb = RGB_FOOD;
        end
    end

    always_ff @(posedge uclk or negedge reset) begin
        if (!reset) r_rgb <= RGB_BLACK;
        else        r_rgb <= w_pix_rgb;
    end

    // -------------------------------------------------------------- outputs
    assign R         = r_rgb.r;
    assign G         = r_rgb.g;
    assign B         = r_rgb.b;
    assign length    = r_length;
    assign score     = r_score;
    assign game_over = w_game_over;

endmodule

// File: tb/tb_snake_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_engine
// Five engine instances share clock, reset and stimulus; each one is set up
// for a different scenario and only its own outputs are checked:
//   0: defaults (movement, direction rules, rendering)
//   1: food at (6,4) (eating, relocation, reset during relocation)
//   2: head on the top row (wall collision, OVER rendering)
//   3: length 5 (U-turn into own body)
//   4: length 4 (U-turn into the vacating tail)
// -----------------------------------------------------------------------------
module tb_snake_engine;

    localparam logic [7:0] C_BLACK = 8'h00;
    localparam logic [7:0] C_HEAD  = 8'h03;
    localparam logic [7:0] C_BODY  = 8'h14;
    localparam logic [7:0] C_FOOD  = 8'hE0;
    localparam logic [7:0] C_BG    = 8'hFF;
    localparam logic [7:0] C_OVER  = 8'h80;

    logic        uclk = 1'b0;
    logic        reset;
    logic        step;
    logic [2:0]  accion;
    logic [10:0] px;
    logic [10:0] py;

    logic [2:0]  r_o     [5];
    logic [2:0]  g_o     [5];
    logic [1:0]  b_o     [5];
    logic [4:0]  len_o   [5];
    logic [7:0]  score_o [5];
    logic        over_o  [5];

    int n_checks = 0;
    int n_errors = 0;

    always #5 uclk = ~uclk;

    snake_engine u_a (
        .uclk(uclk), .reset(reset), .step(step), .accion(accion), .PixelX(px), .PixelY(py),
        .R(r_o[0]), .G(g_o[0]), .B(b_o[0]), .length(len_o[0]), .score(score_o[0]),
        .game_over(over_o[0]));

    snake_engine #(.FOOD0_X(6), .FOOD0_Y(4)) u_b (
        .uclk(uclk), .reset(reset), .step(step), .accion(accion), .PixelX(px), .PixelY(py),
        .R(r_o[1]), .G(g_o[1]), .B(b_o[1]), .length(len_o[1]), .score(score_o[1]),
        .game_over(over_o[1]));

    snake_engine #(.INIT_Y(0)) u_c (
        .uclk(uclk), .reset(reset), .step(step), .accion(accion), .PixelX(px), .PixelY(py),
        .R(r_o[2]), .G(g_o[2]), .B(b_o[2]), .length(len_o[2]), .score(score_o[2]),
        .game_over(over_o[2]));

    snake_engine #(.INIT_LEN(5)) u_d (
        .uclk(uclk), .reset(reset), .step(step), .accion(accion), .PixelX(px), .PixelY(py),
        .R(r_o[3]), .G(g_o[3]), .B(b_o[3]), .length(len_o[3]), .score(score_o[3]),
        .game_over(over_o[3]));

    snake_engine #(.INIT_LEN(4)) u_e (
        .uclk(uclk), .reset(reset), .step(step), .accion(accion), .PixelX(px), .PixelY(py),
        .R(r_o[4]), .G(g_o[4]), .B(b_o[4]), .length(len_o[4]), .score(score_o[4]),
        .game_over(over_o[4]));

    // ------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rgb(input int k);
        return {r_o[k], g_o[k], b_o[k]};
    endfunction

    task automatic tick();
        @(posedge uclk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        step   = 1'b0;
        accion = 3'd0;
        tick();
        reset  = 1'b1;
        tick();
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic set_dir(input logic [2:0] a);
        accion = a;
        tick();
        accion = 3'd0;
    endtask

    task automatic render(input int k, input int x, input int y, input logic [7:0] exp,
                          input string name);
        px = 11'(x);
        py = 11'(y);
        tick();
        check(name, {24'd0, rgb(k)}, {24'd0, exp});
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        logic       st;    // pulse step
        logic [2:0] acc;   // accion during the same cycle
        int         x;     // pixel to render afterwards
        int         y;
        logic [7:0] rgb;   // expected colour at that pixel
        int         len;   // expected length
    } vec_t;

    vec_t tbl [20];

    initial begin
        int     waited;
        int     fx;
        int     fy;
        logic   occ;

        // Head (4,4) heading right, body (3,4),(2,4), food (20,20).
        tbl[0]  = '{1'b0, 3'd0,  45,  45, C_HEAD,  3};
        tbl[1]  = '{1'b0, 3'd0,  35,  45, C_BODY,  3};
        tbl[2]  = '{1'b0, 3'd0,  25,  45, C_BODY,  3};
        tbl[3]  = '{1'b0, 3'd0,  15,  45, C_BG,    3};
        tbl[4]  = '{1'b0, 3'd0, 205, 205, C_FOOD,  3};
        tbl[5]  = '{1'b0, 3'd0, 800,   5, C_BLACK, 3};  // cell x 80: off grid
        tbl[6]  = '{1'b0, 3'd0,   5, 600, C_BLACK, 3};  // cell y 60: off grid
        tbl[7]  = '{1'b1, 3'd0,  55,  45, C_HEAD,  3};  // head (5,4)
        tbl[8]  = '{1'b1, 3'd0,  65,  45, C_HEAD,  3};  // head (6,4)
        tbl[9]  = '{1'b1, 3'd0,  75,  45, C_HEAD,  3};  // head (7,4)
        tbl[10] = '{1'b0, 3'd0,  45,  45, C_BG,    3};  // old tail vacated
        tbl[11] = '{1'b0, 3'd3,  55,  45, C_BODY,  3};  // left = reverse, ignored
        tbl[12] = '{1'b1, 3'd0,  85,  45, C_HEAD,  3};  // still right: (8,4)
        tbl[13] = '{1'b1, 3'd2,  95,  45, C_HEAD,  3};  // down with step: (9,4)
        tbl[14] = '{1'b1, 3'd0,  95,  55, C_HEAD,  3};  // now down: (9,5)
        tbl[15] = '{1'b0, 3'd1,  85,  45, C_BODY,  3};  // up = reverse, ignored
        tbl[16] = '{1'b1, 3'd0,  95,  65, C_HEAD,  3};  // (9,6)
        tbl[17] = '{1'b0, 3'd3,  85,  65, C_BG,    3};  // latch left, no move
        tbl[18] = '{1'b1, 3'd0,  85,  65, C_HEAD,  3};  // (8,6)
        tbl[19] = '{1'b0, 3'd0, 799, 599, C_BG,    3};  // last grid cell (79,59)

        // ---------------------------------------------------- reset values
        reset  = 1'b0;
        step   = 1'b0;
        accion = 3'd0;
        px     = '0;
        py     = '0;
        #12;
        check("rst_len",    32'(len_o[0]),   32'd3);
        check("rst_score",  32'(score_o[0]), 32'd0);
        check("rst_over",   32'(over_o[0]),  32'd0);
        check("rst_rgb",    32'(rgb(0)),     32'(C_BLACK));
        check("rst_fvalid", 32'(u_a.w_food_valid), 32'd1);
        reset = 1'b1;
        tick();

        // ------------------------------------------- table: moves / render
        for (int i = 0; i < 20; i++) begin
            accion = tbl[i].acc;
            step   = tbl[i].st;
            tick();
            accion = 3'd0;
            step   = 1'b0;
            render(0, tbl[i].x, tbl[i].y, tbl[i].rgb, $sformatf("vec%0d_rgb", i));
            check($sformatf("vec%0d_len", i), 32'(len_o[0]), 32'(tbl[i].len));
        end
        check("a_over_none", 32'(over_o[0]), 32'd0);

        // Up from a fresh start turns the head to (4,3).
        do_reset();
        set_dir(3'd1);
        pulse_step();
        render(0, 45, 35, C_HEAD, "turn_up_head");

        // --------------------------------------------------- eat and grow
        do_reset();
        check("b_fvalid0", 32'(u_b.w_food_valid), 32'd1);
        pulse_step();
        check("b_len_before", 32'(len_o[1]), 32'd3);
        pulse_step();
        check("b_len_eat",   32'(len_o[1]),   32'd4);
        check("b_score_eat", 32'(score_o[1]), 32'd1);
        check("b_fvalid_lo", 32'(u_b.w_food_valid), 32'd0);
        waited = 0;
        while (!u_b.w_food_valid && waited < 200) begin
            tick();
            waited++;
        end
        check("b_reloc_done", 32'(u_b.w_food_valid), 32'd1);
        fx  = int'(u_b.w_food_x);
        fy  = int'(u_b.w_food_y);
        occ = ((fx == 6) && (fy == 4)) || ((fx == 5) && (fy == 4)) ||
              ((fx == 4) && (fy == 4)) || ((fx == 3) && (fy == 4));
        check("b_food_in_grid", 32'((fx < 80) && (fy < 60)), 32'd1);
        check("b_food_off_body", 32'(occ), 32'd0);
        render(1, fx * 10 + 5, fy * 10 + 5, C_FOOD, "b_food_red");
        render(1, 35, 45, C_BODY, "b_grown_tail");

        // --------------------------------------- reset during relocation
        do_reset();
        pulse_step();
        pulse_step();
        check("b2_fvalid_lo", 32'(u_b.w_food_valid), 32'd0);
        reset = 1'b0;
        #2;
        check("b2_rst_len",    32'(len_o[1]),   32'd3);
        check("b2_rst_score",  32'(score_o[1]), 32'd0);
        check("b2_rst_fvalid", 32'(u_b.w_food_valid), 32'd1);
        check("b2_rst_food",   32'({u_b.w_food_y, u_b.w_food_x}), {18'd0, 7'd4, 7'd6});
        check("b2_rst_rgb",    32'(rgb(1)), 32'(C_BLACK));
        reset = 1'b1;
        tick();
        pulse_step();
        render(1, 55, 45, C_HEAD, "b2_first_step");

        // ----------------------------------------------- wall at top row
        do_reset();
        set_dir(3'd1);
        check("c_over_pre", 32'(over_o[2]), 32'd0);
        pulse_step();
        check("c_over", 32'(over_o[2]), 32'd1);
        render(2, 105, 5, C_OVER, "c_over_bg");
        pulse_step();
        pulse_step();
        render(2, 45, 5, C_HEAD, "c_frozen_head");
        render(2, 35, 5, C_BODY, "c_frozen_body");
        check("c_len", 32'(len_o[2]), 32'd3);

        // ------------------------------------------------------ U-turns
        do_reset();
        set_dir(3'd1);
        pulse_step();
        set_dir(3'd3);
        pulse_step();
        check("d_over_pre", 32'(over_o[3]), 32'd0);
        check("e_over_pre", 32'(over_o[4]), 32'd0);
        set_dir(3'd2);
        pulse_step();
        check("d_self_hit", 32'(over_o[3]), 32'd1);
        check("e_tail_ok",  32'(over_o[4]), 32'd0);
        render(3, 35, 35, C_HEAD, "d_frozen_head");
        render(4, 35, 45, C_HEAD, "e_head_on_tail");
        check("d_len", 32'(len_o[3]), 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case a wait above misbehaves.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
